whack_judge: RTL

//  Consumer end of the mole-position interface. Takes the current mole hole and its change strobe,

---
 rtl/whack_pkg.sv | 15 +
 rtl/btn_edge_detect.sv | 22 ++
 rtl/whack_judge.sv | 135 +++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game: hole count, the "no mole" code
// and the judge state encoding used by the generator, judge and display.
package whack_pkg;

  localparam int         NUM_HOLES = 5;
  localparam logic [2:0] NO_MOLE   = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIT_WAIT,
    OVER
  } state_t;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for the debounced button levels; one press bit per hole.
module btn_edge_detect #(
  parameter int DATA_W = whack_pkg::NUM_HOLES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_buttons,
  output logic [DATA_W-1:0] o_press
);

  logic [DATA_W-1:0] r_btn_q;

  // All-ones history masks the first cycle after reset, so a button held
  // through reset never looks like a fresh press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_btn_q <= '1;
    else       r_btn_q <= i_buttons;
  end

  assign o_press = i_buttons & ~r_btn_q;

endmodule

// File: rtl/whack_judge.sv
// Judges button presses against the current mole hole, keeps score and lives,
// and requests a new mole position after every hit.
module whack_judge #(
  parameter int NUM_HOLES   = whack_pkg::NUM_HOLES,
  parameter int SCORE_W     = 8,
  parameter int LIVES_W     = 3,
  parameter int START_LIVES = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_restart_game,
  input  logic [2:0]           i_mole_position,
  input  logic                 i_position_changed,
  input  logic [NUM_HOLES-1:0] i_buttons,
  output logic                 o_change_position,
  output logic                 o_hit,
  output logic                 o_miss,
  output logic [SCORE_W-1:0]   o_score,
  output logic [LIVES_W-1:0]   o_lives,
  output logic                 o_game_over
);
  import whack_pkg::*;

  localparam int                TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  state_t               r_state, w_state_nx;
  logic [SCORE_W-1:0]   r_score, w_score_nx;
  logic [LIVES_W-1:0]   r_lives, w_lives_nx;
  logic [TMR_W-1:0]     r_timer, w_timer_nx;
  logic                 r_hit, w_hit_nx;
  logic                 r_miss, w_miss_nx;
  logic                 r_change, w_change_nx;
  logic                 w_lose;
  logic [NUM_HOLES-1:0] w_press;
  logic [NUM_HOLES-1:0] w_target;
  logic                 w_pos_valid;
  logic                 w_correct;

  btn_edge_detect #(.DATA_W(NUM_HOLES)) u_edge (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_buttons (i_buttons),
    .o_press   (w_press)
  );

  assign w_pos_valid = int'(i_mole_position) < NUM_HOLES;
  assign w_target    = NUM_HOLES'(1) << i_mole_position;
  // Exactly one press bit, on the mole's hole; multi-press never matches.
  assign w_correct   = w_pos_valid && (w_press == w_target);

  always_comb begin
    w_state_nx  = r_state;
    w_score_nx  = r_score;
    w_lives_nx  = r_lives;
    w_timer_nx  = r_timer;
    w_hit_nx    = 1'b0;
    w_miss_nx   = 1'b0;
    w_change_nx = 1'b0;
    w_lose      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_position_changed && w_pos_valid) w_state_nx = ARMED;
      end
      ARMED: begin
        if (w_pos_valid && (|w_press)) begin
          if (w_correct) begin
            w_hit_nx   = 1'b1;
            w_score_nx = sat_inc(r_score);
            // A simultaneous strobe means the generator already moved the mole.
            if (!i_position_changed) begin
              w_change_nx = 1'b1;
              w_timer_nx  = '0;
              w_state_nx  = HIT_WAIT;
            end
          end else begin
            w_lose = 1'b1;
          end
        end else if (i_position_changed) begin
          w_lose = 1'b1;
        end
      end
      HIT_WAIT: begin
        if (i_position_changed) begin
          w_state_nx = ARMED;
        end else if (r_timer == TMR_LAST) begin
          w_change_nx = 1'b1;
          w_timer_nx  = '0;
        end else begin
          w_timer_nx = r_timer + TMR_W'(1);
        end
      end
      OVER: ;
      default: w_state_nx = IDLE;
    endcase
    if (w_lose && (r_lives != '0)) begin
      w_miss_nx  = 1'b1;
      w_lives_nx = r_lives - LIVES_W'(1);
      if (r_lives == LIVES_W'(1)) w_state_nx = OVER;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_restart_game) begin
      r_state  <= IDLE;
      r_score  <= '0;
      r_lives  <= LIVES_W'(START_LIVES);
      r_timer  <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_score  <= w_score_nx;
      r_lives  <= w_lives_nx;
      r_timer  <= w_timer_nx;
      r_hit    <= w_hit_nx;
      r_miss   <= w_miss_nx;
      r_change <= w_change_nx;
    end
  end

  assign o_change_position = r_change;
  assign o_hit             = r_hit;
  assign o_miss            = r_miss;
  assign o_score           = r_score;
  assign o_lives           = r_lives;
  assign o_game_over       = (r_state == OVER);

endmodule
